// File: rtl/galois_pkg.sv
// galois_pkg: shared constants and types for the BN254 scalar-field blocks.
//   BN254_R   : field modulus r.
//   E_ROOT5   : 5^-1 mod (r-1); raising to this power undoes x^5.
//   E_MSB     : index of the highest set bit of E_ROOT5.
//   IDX_W     : width of an exponent bit index.
//   root_state_t : control states of galois_root_5.
`timescale 1ns/1ps
package galois_pkg;

    localparam int N_BITS_BN254 = 254;

    localparam logic [253:0] BN254_R =
        254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

    // r-1 is 1 mod 5, so 4*(r-1)+1 is divisible by 5 and the quotient times 5
    // is 1 mod (r-1). The quotient is the fifth-root exponent.
    localparam logic [257:0] E_ROOT5_NUM = ({4'd0, BN254_R} - 258'd1) * 258'd4 + 258'd1;
    localparam logic [253:0] E_ROOT5     = 254'(E_ROOT5_NUM / 258'd5);

    function automatic int msb_index(input logic [253:0] v);
        int m;
        m = 0;
        for (int i = 0; i < 254; i++) begin
            if (v[i]) m = i;
        end
        return m;
    endfunction

    localparam int E_MSB = msb_index(E_ROOT5);
    localparam int IDX_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQR  = 2'd1,
        MUL  = 2'd2,
        FIN  = 2'd3
    } root_state_t;

endpackage

// File: rtl/galois_mult.sv
// galois_mult: modular multiplier, result = a*b mod PRIME.
// Level-enable protocol: hold en high until done; done stays high while en
// is high; en must go low for at least one cycle before the next operation.
// Dropping en at any time abandons the operation and clears done.
//   clk, rst (async, active-high)
//   en      : start/hold
//   a, b    : operands, both < PRIME
//   result  : product mod PRIME, valid while done=1
//   done    : completion flag
// Methods: "peasant" (one multiplier bit per cycle, MSB first, N_BITS+1
// cycles) and "direct" (single registered multiply-and-reduce).
`timescale 1ns/1ps
module galois_mult
    import galois_pkg::*;
#(
    parameter int                N_BITS             = 254,
    parameter logic [N_BITS-1:0] PRIME              = BN254_R,
    parameter                    GALOIS_MULT_METHOD = "peasant"
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N_BITS-1:0] a,
    input  logic [N_BITS-1:0] b,
    output logic [N_BITS-1:0] result,
    output logic              done
);

    logic [N_BITS-1:0] result_reg;
    logic              done_reg;

    generate
        if (GALOIS_MULT_METHOD == "direct") begin : g_direct
            logic [2*N_BITS-1:0] prod_full;
            logic [N_BITS-1:0]   prod_red;

            always_comb begin
                prod_full = {{N_BITS{1'b0}}, a} * {{N_BITS{1'b0}}, b};
                prod_red  = N_BITS'(prod_full % {{N_BITS{1'b0}}, PRIME});
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    result_reg <= '0;
                    done_reg   <= 1'b0;
                end else if (!en) begin
                    done_reg <= 1'b0;
                end else if (!done_reg) begin
                    result_reg <= prod_red;
                    done_reg   <= 1'b1;
                end
            end
        end else begin : g_peasant
            localparam int CNT_W = $clog2(N_BITS + 1);

            logic [N_BITS-1:0] a_reg;
            logic [N_BITS-1:0] b_reg;
            logic [N_BITS-1:0] acc_reg;
            logic [CNT_W-1:0]  cnt_reg;
            logic              busy_reg;

            logic [N_BITS:0]   dbl;
            logic [N_BITS-1:0] dbl_red;
            logic [N_BITS:0]   sum;
            logic [N_BITS-1:0] sum_red;
            logic [N_BITS-1:0] step_next;

            // acc < PRIME, so 2*acc and acc+a are both < 2*PRIME and a single
            // conditional subtract restores full reduction.
            always_comb begin
                dbl       = {acc_reg, 1'b0};
                dbl_red   = (dbl >= {1'b0, PRIME}) ? N_BITS'(dbl - {1'b0, PRIME})
                                                   : dbl[N_BITS-1:0];
                sum       = {1'b0, dbl_red} + {1'b0, a_reg};
                sum_red   = (sum >= {1'b0, PRIME}) ? N_BITS'(sum - {1'b0, PRIME})
                                                   : sum[N_BITS-1:0];
                step_next = b_reg[N_BITS-1] ? sum_red : dbl_red;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_reg      <= '0;
                    b_reg      <= '0;
                    acc_reg    <= '0;
                    cnt_reg    <= '0;
                    busy_reg   <= 1'b0;
                    result_reg <= '0;
                    done_reg   <= 1'b0;
                end else if (!en) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b0;
                end else if (busy_reg) begin
                    acc_reg <= step_next;
                    b_reg   <= b_reg << 1;
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        busy_reg   <= 1'b0;
                        done_reg   <= 1'b1;
                        result_reg <= step_next;
                    end
                end else if (!done_reg) begin
                    a_reg    <= a;
                    b_reg    <= b;
                    acc_reg  <= '0;
                    cnt_reg  <= CNT_W'(N_BITS);
                    busy_reg <= 1'b1;
                end
            end
        end
    endgenerate

    assign result = result_reg;
    assign done   = done_reg;

endmodule

// File: rtl/galois_root_5.sv
// galois_root_5: fifth root in GF(PRIME), result = base^E_ROOT5 mod PRIME.
// Inverse of x -> x^5. Fixed-exponent left-to-right square-and-multiply using
// one shared galois_mult; the schedule depends only on the exponent, so the
// latency is identical for every base.
//   clk, rst (async, active-high)
//   en     : level start/hold; keep high until done, then drop
//   base   : operand < PRIME, sampled once at start
//   result : base^E_ROOT5 mod PRIME, valid while done=1, held until next
//            completion or reset
//   done   : completion flag
`timescale 1ns/1ps
module galois_root_5
    import galois_pkg::*;
#(
    parameter int                N_BITS             = 254,
    parameter logic [N_BITS-1:0] PRIME              = BN254_R,
    parameter                    GALOIS_MULT_METHOD = "peasant"
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N_BITS-1:0] base,
    output logic [N_BITS-1:0] result,
    output logic              done
);

    root_state_t       state_reg,   state_next;
    logic [N_BITS-1:0] acc_reg,     acc_next;
    logic [N_BITS-1:0] base_q_reg,  base_q_next;
    logic [IDX_W-1:0]  idx_reg,     idx_next;
    logic [N_BITS-1:0] result_reg,  result_next;
    logic              done_reg,    done_next;
    logic              mult_en_reg, mult_en_next;

    logic [N_BITS-1:0] mult_b;
    logic [N_BITS-1:0] mult_result;
    logic              mult_done;

    // Squaring uses acc for both operands; the multiply step folds in base.
    assign mult_b = (state_reg == MUL) ? base_q_reg : acc_reg;

    galois_mult #(
        .N_BITS             (N_BITS),
        .PRIME              (PRIME),
        .GALOIS_MULT_METHOD (GALOIS_MULT_METHOD)
    ) u_mult (
        .clk    (clk),
        .rst    (rst),
        .en     (mult_en_reg),
        .a      (acc_reg),
        .b      (mult_b),
        .result (mult_result),
        .done   (mult_done)
    );

    always_comb begin
        state_next   = state_reg;
        acc_next     = acc_reg;
        base_q_next  = base_q_reg;
        idx_next     = idx_reg;
        result_next  = result_reg;
        done_next    = done_reg;
        mult_en_next = mult_en_reg;

        case (state_reg)
            IDLE: begin
                done_next    = 1'b0;
                mult_en_next = 1'b0;
                if (en) begin
                    // The exponent MSB is consumed by loading acc with base.
                    base_q_next = base;
                    acc_next    = base;
                    idx_next    = IDX_W'(E_MSB - 1);
                    state_next  = SQR;
                end
            end

            SQR, MUL: begin
                if (!en) begin
                    mult_en_next = 1'b0;
                    state_next   = IDLE;
                end else if (!mult_en_reg) begin
                    // Entered with en low so the multiplier has re-armed.
                    mult_en_next = 1'b1;
                end else if (mult_done) begin
                    acc_next     = mult_result;
                    mult_en_next = 1'b0;
                    if (state_reg == SQR && E_ROOT5[idx_reg]) begin
                        state_next = MUL;
                    end else if (idx_reg == '0) begin
                        state_next = FIN;
                    end else begin
                        idx_next   = idx_reg - IDX_W'(1);
                        state_next = SQR;
                    end
                end
            end

            FIN: begin
                if (!en) begin
                    done_next  = 1'b0;
                    state_next = IDLE;
                end else begin
                    result_next = acc_reg;
                    done_next   = 1'b1;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            acc_reg     <= '0;
            base_q_reg  <= '0;
            idx_reg     <= '0;
            result_reg  <= '0;
            done_reg    <= 1'b0;
            mult_en_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            acc_reg     <= acc_next;
            base_q_reg  <= base_q_next;
            idx_reg     <= idx_next;
            result_reg  <= result_next;
            done_reg    <= done_next;
            mult_en_reg <= mult_en_next;
        end
    end

    assign result = result_reg;
    assign done   = done_reg;

endmodule
